// File: rtl/timing_sequencer_if.sv
// Control/status bundle between the MERC-16 control FSM and the step sequencer.
// The sequencer sits on the slave side; the FSM or a bench drives the master side.
interface timing_sequencer_if #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 2**N
);
    logic         enable;
    logic         clear;
    logic         load;
    logic [N-1:0] load_step;
    logic [N-1:0] last_step;
    logic [N-1:0] step;
    logic [M-1:0] out;
    logic         invalid;
    logic         wrap;

    modport master (
        output enable, clear, load, load_step, last_step,
        input  step, out, invalid, wrap
    );

    modport slave (
        input  enable, clear, load, load_step, last_step,
        output step, out, invalid, wrap
    );
endinterface

// File: rtl/timing_sequencer.sv
// One-hot T-state sequencer: binary step counter with clear/load/enable priority,
// programmable terminal step, and a combinational one-hot decode of the step register.
module timing_sequencer #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 2**N
) (
    input  logic                clk,
    input  logic                rst,
    timing_sequencer_if.slave   bus
);
    localparam int unsigned STEP_W = N;

    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic              wrap_q;
    logic              wrap_d;
    logic [M-1:0]      out_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end

    // Next step: clear beats load beats enable; a counted return to 0 raises wrap
    always_comb begin
        step_d = step_q;
        wrap_d = 1'b0;
        if (bus.clear) begin
            step_d = '0;
        end else if (bus.load) begin
            step_d = bus.load_step;
        end else if (bus.enable) begin
            if ((step_q == bus.last_step) || (step_q == '1)) begin
                step_d = '0;
                wrap_d = 1'b1;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
    end

    // One-hot decode straight off the register, so no input reaches the strobes
    always_comb begin
        out_c = '0;
        for (int unsigned k = 0; k < M; k++) begin
            out_c[k] = (step_q == STEP_W'(k));
        end
    end

    generate
        if (M >= 2**N) begin : g_full
            assign bus.invalid = 1'b0;
        end else begin : g_part
            assign bus.invalid = (step_q >= STEP_W'(M));
        end
    endgenerate

    assign bus.step = step_q;
    assign bus.out  = out_c;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_timing_sequencer.sv
// Directed bench for timing_sequencer: a 16-step and a 10-output instance share
// clock and reset; expected step/out/invalid/wrap values queue up per edge.
module tb_timing_sequencer;
    logic clk;
    logic rst;

    timing_sequencer_if #(.N(4), .M(16)) i16 ();
    timing_sequencer_if #(.N(4), .M(10)) i10 ();

    timing_sequencer #(.N(4), .M(16)) dut16 (.clk(clk), .rst(rst), .bus(i16));
    timing_sequencer #(.N(4), .M(10)) dut10 (.clk(clk), .rst(rst), .bus(i10));

    typedef struct {
        int          sel;
        string       tag;
        logic [3:0]  step;
        logic [15:0] out;
        logic        inv;
        logic        wrap;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected values derived from the step number alone
    task automatic push_exp(input int sel, input string tag, input int s, input bit w);
        exp_t e;
        int   m;
        m      = (sel == 0) ? 16 : 10;
        e.sel  = sel;
        e.tag  = tag;
        e.step = 4'(s);
        e.out  = (s < m) ? (16'h0001 << s) : 16'h0000;
        e.inv  = (s >= m);
        e.wrap = w;
        sb.push_back(e);
    endtask

    task automatic check_one();
        exp_t        e;
        logic [3:0]  o_step;
        logic [15:0] o_out;
        logic        o_inv;
        logic        o_wrap;
        checks++;
        assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=>0", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 0) begin
                o_step = i16.step; o_out = i16.out;
                o_inv  = i16.invalid; o_wrap = i16.wrap;
            end else begin
                o_step = i10.step; o_out = 16'(i10.out);
                o_inv  = i10.invalid; o_wrap = i10.wrap;
            end
            checks++;
            assert (o_step === e.step) else begin
                failures++;
                $error("FAIL %s.step observed=%0d expected=%0d", e.tag, o_step, e.step);
            end
            checks++;
            assert (o_out === e.out) else begin
                failures++;
                $error("FAIL %s.out observed=%h expected=%h", e.tag, o_out, e.out);
            end
            checks++;
            assert (o_inv === e.inv) else begin
                failures++;
                $error("FAIL %s.invalid observed=%b expected=%b", e.tag, o_inv, e.inv);
            end
            checks++;
            assert (o_wrap === e.wrap) else begin
                failures++;
                $error("FAIL %s.wrap observed=%b expected=%b", e.tag, o_wrap, e.wrap);
            end
        end
    endtask

    task automatic edge_check();
        @(posedge clk);
        #1;
        check_one();
    endtask

    initial begin
        rst = 1'b0;
        i16.enable = 1'b0; i16.clear = 1'b0; i16.load = 1'b0;
        i16.load_step = 4'd0; i16.last_step = 4'd15;
        i10.enable = 1'b0; i10.clear = 1'b0; i10.load = 1'b0;
        i10.load_step = 4'd0; i10.last_step = 4'd15;

        // Reset pulse between t=1 and t=3, before the first edge at t=5
        #1 rst = 1'b1;
        #1;
        push_exp(0, "reset_during", 0, 1'b0); check_one();
        push_exp(1, "reset_during10", 0, 1'b0); check_one();
        #1 rst = 1'b0;
        #1;
        push_exp(0, "reset_after", 0, 1'b0); check_one();

        // Full lap with terminal step 15
        i16.enable = 1'b1; i16.last_step = 4'd15;
        for (int i = 1; i <= 16; i++) begin
            push_exp(0, "full_lap", i % 16, i == 16);
            edge_check();
        end

        // Short lap with terminal step 4
        i16.last_step = 4'd4;
        for (int i = 1; i <= 10; i++) begin
            push_exp(0, "short_lap", i % 5, (i % 5) == 0);
            edge_check();
        end

        // Load beats enable
        i16.load = 1'b1; i16.load_step = 4'd9; i16.enable = 1'b1;
        push_exp(0, "load9", 9, 1'b0);
        edge_check();

        // Clear beats load and enable
        i16.clear = 1'b1;
        push_exp(0, "clear_all", 0, 1'b0);
        edge_check();

        // Idle cycles hold the step
        i16.clear = 1'b0; i16.load = 1'b0; i16.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_exp(0, "hold", 0, 1'b0);
            edge_check();
        end

        // Terminal step 0 with enable held: wrap every cycle
        i16.last_step = 4'd0; i16.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_exp(0, "last0", 0, 1'b1);
            edge_check();
        end

        // Count to 7, then async reset between edges
        i16.last_step = 4'd15;
        for (int i = 1; i <= 7; i++) begin
            push_exp(0, "count7", i, 1'b0);
            edge_check();
        end
        #2 rst = 1'b1;
        #1;
        push_exp(0, "async_rst", 0, 1'b0); check_one();
        #1 rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            push_exp(0, "post_rst", i, 1'b0);
            edge_check();
        end
        i16.enable = 1'b0;

        // Out-of-range load on the 10-output instance
        i10.load = 1'b1; i10.load_step = 4'd12;
        push_exp(1, "oor_load12", 12, 1'b0);
        edge_check();
        i10.load = 1'b0; i10.enable = 1'b1; i10.last_step = 4'd15;
        for (int i = 13; i <= 16; i++) begin
            push_exp(1, "oor_run", i % 16, i == 16);
            edge_check();
        end

        // Terminal step beyond M: steps 10 and 11 read invalid
        i10.last_step = 4'd11;
        for (int i = 1; i <= 12; i++) begin
            push_exp(1, "last11", i % 12, (i % 12) == 0);
            edge_check();
        end
        i10.enable = 1'b0;

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/timing_sequencer.md
# timing_sequencer

Parametrised one-hot step sequencer for the MERC-16 control unit: a binary step counter whose state is decoded to an M-wide one-hot bus every cycle. It generalises the combinational N-to-M decoder into a clocked block with enable, clear, load-to-step and programmable terminal count. The control FSM consumes the one-hot `Out` as T-state strobes.

## Interface
- `N`, default 4: width of the step counter, `LoadStep` and `LastStep`.
- `M`, default 2**N: width of the one-hot output. Legal range is 1 ≤ M ≤ 2**N.

- `Clock`  in  1: single clock; all state changes on its rising edge.
- `Reset`  in  1: asynchronous, active-high; clears all state immediately.
- `Enable`  in  1: advance one step this cycle.
- `Clear`  in  1: synchronous return to step 0.
- `Load`  in  N: no, see below; `Load` is in, 1 bit: synchronous jump to `LoadStep`.
- `LoadStep`  in  N: target step for `Load`.
- `LastStep`  in  N: terminal step; it is sampled every cycle.
- `Step`  out  N: current step, binary, registered.
- `Out`  out  M: one-hot decode of `Step`. It is all-zero when `Step` ≥ M.
- `Invalid`  out  1: high when `Step` ≥ M.
- `Wrap`  out  1: one-cycle pulse marking a counted return to step 0.

## Operation
- Reset values:
  - `Step` = 0.
  - `Out` = 1 (bit 0 set).
  - `Invalid` = 0.
  - `Wrap` = 0.
- Per-edge priority: `Clear` > `Load` > `Enable` > hold.
- `Clear`:
  - `Step` ← 0.
  - `Wrap` ← 0.
- `Load`:
  - `Step` ← `LoadStep`. No range check is done.
  - `Wrap` ← 0.
- `Enable` with `Step` == `LastStep`: `Step` ← 0 and `Wrap` ← 1.
- `Enable` with `Step` == 2**N−1 and `Step` ≠ `LastStep`: `Step` ← 0 (natural wrap) and `Wrap` ← 1.
- `Enable` in any other case:
  - `Step` ← `Step`+1, modulo 2**N.
  - `Wrap` ← 0.
- No operation this cycle: `Step` holds and `Wrap` ← 0.
- `Out` and `Invalid` are pure combinational functions of the `Step` register. They carry no additional register stage and contain no glitch-causing logic from inputs.
  - `Out`[k] = (`Step` == k) for k < M.
  - `Invalid` = (`Step` ≥ M). It is constant 0 when M == 2**N.
- A `Load` of a step above `LastStep` is legal. The counter then runs up to 2**N−1 and wraps naturally. `LastStep` is not hit until the next lap.
- `LastStep` ≥ M is legal. The steps in M..`LastStep` show `Out` = 0 and `Invalid` = 1.
- Exactly zero or one bit of `Out` is ever set.

## Timing
- Latency: a control input sampled at edge t is reflected on `Step`, `Out`, `Invalid` and `Wrap` after edge t.
- `Wrap` is registered. It is high for exactly the cycle in which `Step` first reads 0 after a counted wrap. If `Enable` stays high and `LastStep` == 0, `Wrap` stays high every cycle.
- `Reset` asserted mid-sequence forces the reset values immediately, without waiting for a clock edge. The first edge after deassertion is processed normally.
- Inputs that change while `Reset` is high are ignored.
- Simultaneous `Clear` + `Load` + `Enable` gives `Step` = 0 and `Wrap` = 0.

## Test plan
- **Reset** (N=4, M=16): pulse `Reset` with no clock edge. Require `Out`=16'h0001, `Step`=0, `Wrap`=0, `Invalid`=0 during and after the pulse.
- **Full lap** (`Enable`=1, `LastStep`=15, 16 edges):
  - `Out` walks 16'h0002 … 16'h8000, then 16'h0001.
  - `Wrap`=1 only in the cycle `Step` returns to 0.
- **Short lap** (`LastStep`=4, `Enable`=1 for 10 edges):
  - `Step` sequence is 1,2,3,4,0,1,2,3,4,0.
  - `Wrap` is high exactly twice, in the two cycles where `Step`=0.
- **Load and priority**:
  - `Load`=1, `LoadStep`=9, `Enable`=1 gives `Step`=9, `Out`=16'h0200, `Wrap`=0.
  - The next edge with `Clear`=`Load`=`Enable`=1 gives `Step`=0, `Wrap`=0.
  - Then `Enable`=0 for 3 edges: `Step` holds at 0.
- **Out-of-range** (N=4, M=10 instance):
  - `Load` `LoadStep`=12 gives `Out`=10'h000 and `Invalid`=1.
  - Then `Enable` 4 edges: `Step` runs 13,14,15,0. `Wrap`=1 at 0, and `Out`=10'h001 with `Invalid`=0.
- **Async reset mid-count**: count to `Step`=7, then assert `Reset` between edges. Require `Out`=16'h0001 before the next edge; after release, counting resumes from 0.
